lcd_text_writer: RTL
====================

Name: lcd_text_writer

Overview:
- 32-character frame buffer (2 rows x 16 columns) that sits directly upstream of the character LCD controller and drives its START/CLEAR/CHARACTER/ADDRESS interface.
- Client logic writes characters into the buffer at any time.
- The block tracks which positions have changed and streams them to the LCD one at a time, with a fixed spacing between them.
- It also sequences full-screen clears.

Parameters:
CHAR_GAP, 45000, minimum i_clk cycles from one o_lcd_start pulse to the next scan (covers command + data write at LCD side)
CLR_TIMEOUT, 1024, max cycles waiting for i_lcd_busy to rise after o_lcd_clear before proceeding anyway

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_wr_en  in  1  write strobe, one char per cycle
i_wr_pos  in  5  buffer position; 0-15 = row 0 col 0-15, 16-31 = row 1 col 0-15
i_wr_char  in  8  character code
i_clear_req  in  1  request: blank buffer and clear LCD
i_lcd_busy  in  1  LCD controller BUSY
o_lcd_start  out  1  one-cycle write pulse to LCD
o_lcd_clear  out  1  one-cycle clear pulse to LCD
o_lcd_char  out  8  character to LCD, held stable between pulses
o_lcd_addr  out  8  DDRAM set-address command byte, held stable between pulses
o_pending  out  1  any dirty position or clear outstanding

Behaviour:
- Reset values:
  - Buffer: all 0x20; dirty bits all 0; scan pointer 0; clear-pending flag 0.
  - Outputs: o_lcd_start 0, o_lcd_clear 0, o_lcd_char 0x20, o_lcd_addr 0x80, o_pending 0.
  - State INIT_WAIT.
- Client writes:
  - i_wr_en: buf[pos] <= char, dirty[pos] <= 1 on the next edge.
  - Accepted in every state; there is no back-pressure.
  - Rewriting an already-dirty position keeps one pending send, carrying the latest char.
- Address map: o_lcd_addr = 0x80 + p for p < 16; 0xC0 + (p - 16) for p >= 16.
- i_clear_req sets the clear-pending flag (a level held high acts as a single request).
- o_pending = OR(dirty) | clear-pending | state in CLR_*; registered.
- FSM:
  - INIT_WAIT: stay while i_lcd_busy = 1 (LCD boot); go to SCAN when it is 0.
  - SCAN:
    - If clear-pending: go to CLR_ISSUE.
    - Else if dirty[ptr] and i_lcd_busy = 0: go to ISSUE.
    - Else ptr <= ptr + 1 (31 wraps to 0).
    - One position is examined per cycle, so worst-case discovery latency is 32 cycles.
  - ISSUE (1 cycle):
    - o_lcd_start = 1; o_lcd_char = buf[ptr]; o_lcd_addr = map(ptr).
    - char/addr are registered one cycle before or with the pulse and are stable during it.
    - dirty[ptr] <= 0, unless a client write to ptr lands in this same cycle; then dirty stays 1 and the new char is resent later.
    - Load gap counter with CHAR_GAP - 1; ptr <= ptr + 1; go to GAP.
  - GAP: count down; at 0 go to SCAN.
    - The LCD's BUSY does not rise on character writes, so spacing is guaranteed solely by this counter.
  - CLR_ISSUE (1 cycle):
    - o_lcd_clear = 1.
    - Buffer <= all 0x20; dirty <= all 0; clear-pending <= 0; ptr <= 0.
    - Go to CLR_WAIT_HI.
  - CLR_WAIT_HI: wait for i_lcd_busy = 1, or CLR_TIMEOUT cycles elapsed; then go to CLR_WAIT_LO.
  - CLR_WAIT_LO: wait for i_lcd_busy = 0; then go to SCAN.
- Simultaneous client write and clear in the CLR_ISSUE cycle: the write takes effect after the blanking (that position holds the new char, dirty = 1).
- i_clear_req arriving during ISSUE/GAP: latched and served at the next SCAN; the in-flight character completes.
- o_lcd_start and o_lcd_clear are never asserted in the same cycle, and neither is asserted while i_lcd_busy = 1 at SCAN.
- Reset mid-operation: everything returns to reset values immediately; pulses drop asynchronously.

Test Plan:
- Reset with i_lcd_busy = 1 for 100 cycles, then 0 -> no pulses before busy falls; o_pending = 0; o_lcd_addr = 0x80.
- Write 'A' (0x41) at pos 0 and 'B' at pos 17 -> exactly two o_lcd_start pulses, (0x80, 0x41) then (0xC1, 0x42), at least CHAR_GAP cycles apart; o_pending falls after the second.
- Write pos 5 = 'x', then pos 5 = 'y' before its issue -> single pulse (0x85, 0x79).
- Write pos 3 in the exact ISSUE cycle for pos 3 -> a second pulse for pos 3 carrying the new char.
- Fill 4 dirty positions, assert i_clear_req during the GAP of the first -> first char completes, then o_lcd_clear pulse, wait for busy high then low, no further starts; buffer reads 0x20 and o_pending = 0.
- i_clear_req with i_lcd_busy stuck 0 -> CLR_WAIT_HI exits after CLR_TIMEOUT cycles; then a write at pos 31 issues (0xCF, char).

Source files
------------

// File: rtl/lcd_text_writer.sv
// -----------------------------------------------------------------------------
// lcd_text_writer
//
// A 2x16 character frame buffer that sits in front of a character-LCD
// controller. Client logic writes characters at any time. The block remembers
// which positions changed and sends them to the LCD one at a time, leaving a
// fixed number of cycles between sends. It also sequences full-screen clears.
//
// Ports
//   i_clk, i_rst     clock; asynchronous active-high reset
//   i_wr_en          write strobe, one character per cycle
//   i_wr_pos[4:0]    0-15 = row 0 col 0-15, 16-31 = row 1 col 0-15
//   i_wr_char[7:0]   character code to store
//   i_clear_req      request to blank the buffer and clear the LCD
//                    (a held level counts as a single request)
//   i_lcd_busy       BUSY from the LCD controller
//   o_lcd_start      one-cycle character write pulse
//   o_lcd_clear      one-cycle clear pulse
//   o_lcd_char[7:0]  character for the current/last write, held between pulses
//   o_lcd_addr[7:0]  DDRAM set-address command byte, held between pulses
//   o_pending        a dirty position or a clear is still outstanding
// -----------------------------------------------------------------------------
module lcd_text_writer #(
  parameter int CHAR_GAP    = 45000,
  parameter int CLR_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_pos,
  input  logic [7:0] i_wr_char,
  input  logic       i_clear_req,
  input  logic       i_lcd_busy,
  output logic       o_lcd_start,
  output logic       o_lcd_clear,
  output logic [7:0] o_lcd_char,
  output logic [7:0] o_lcd_addr,
  output logic       o_pending
);

  localparam int GAP_W = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
  localparam int TO_W  = (CLR_TIMEOUT > 1) ? $clog2(CLR_TIMEOUT) : 1;
  localparam logic [7:0] BLANK = 8'h20;

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_SCAN,
    ST_ISSUE,
    ST_GAP,
    ST_CLR_ISSUE,
    ST_CLR_WAIT_HI,
    ST_CLR_WAIT_LO
  } state_e;

  // Row 0 maps to DDRAM 0x00-0x0F, row 1 to 0x40-0x4F; bit 7 is the
  // set-address command bit.
  function automatic logic [7:0] addr_map(input logic [4:0] p);
    return {1'b1, p[4], 2'b00, p[3:0]};
  endfunction

  state_e             state_q, state_d;
  logic [7:0]         fb_q [32];
  logic [7:0]         fb_d [32];
  logic [31:0]        dirty_q, dirty_d;
  logic [4:0]         ptr_q, ptr_d;
  logic               clr_pend_q, clr_pend_d;
  logic               clr_req_prev_q, clr_req_prev_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [7:0]         char_q, char_d;
  logic [7:0]         addr_q, addr_d;
  logic               pending_q, pending_d;

  logic               clr_rise;
  logic               wr_hit_ptr;

  always_comb begin
    state_d        = state_q;
    fb_d           = fb_q;
    dirty_d        = dirty_q;
    ptr_d          = ptr_q;
    clr_pend_d     = clr_pend_q;
    clr_req_prev_d = i_clear_req;
    gap_d          = gap_q;
    to_d           = to_q;
    char_d         = char_q;
    addr_d         = addr_q;

    clr_rise   = i_clear_req & ~clr_req_prev_q;
    wr_hit_ptr = i_wr_en && (i_wr_pos == ptr_q);

    unique case (state_q)
      ST_INIT_WAIT: begin
        if (!i_lcd_busy) state_d = ST_SCAN;
      end

      ST_SCAN: begin
        if (clr_pend_q) begin
          // Hold the scan where it is until the LCD is idle.
          if (!i_lcd_busy) state_d = ST_CLR_ISSUE;
        end else if (dirty_q[ptr_q] && !i_lcd_busy) begin
          state_d = ST_ISSUE;
          // A write to this position landing now must be the one sent,
          // because the dirty bit is dropped during the pulse.
          char_d  = wr_hit_ptr ? i_wr_char : fb_q[ptr_q];
          addr_d  = addr_map(ptr_q);
        end else begin
          ptr_d = ptr_q + 5'd1;
        end
      end

      ST_ISSUE: begin
        gap_d   = GAP_W'(CHAR_GAP - 1);
        ptr_d   = ptr_q + 5'd1;
        state_d = ST_GAP;
      end

      // BUSY does not rise for character writes, so this counter alone
      // spaces consecutive pulses.
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_SCAN;
        else             gap_d   = gap_q - 1'b1;
      end

      ST_CLR_ISSUE: begin
        ptr_d   = 5'd0;
        to_d    = '0;
        state_d = ST_CLR_WAIT_HI;
      end

      // The clear may be too quick for BUSY to be seen; give up after a bound.
      ST_CLR_WAIT_HI: begin
        if (i_lcd_busy || (to_q == TO_W'(CLR_TIMEOUT - 1))) state_d = ST_CLR_WAIT_LO;
        else                                                   to_d    = to_q + 1'b1;
      end

      ST_CLR_WAIT_LO: begin
        if (!i_lcd_busy) state_d = ST_SCAN;
      end

      default: state_d = ST_INIT_WAIT;
    endcase

    // Blanking first, then the sent bit, then client writes: a write in the
    // same cycle always survives with its dirty bit set.
    if (state_q == ST_CLR_ISSUE) begin
      for (int i = 0; i < 32; i++) fb_d[i] = BLANK;
      dirty_d    = '0;
      clr_pend_d = 1'b0;
    end
    if (state_q == ST_ISSUE) dirty_d[ptr_q] = 1'b0;
    if (i_wr_en) begin
      fb_d[i_wr_pos]    = i_wr_char;
      dirty_d[i_wr_pos] = 1'b1;
    end
    if (clr_rise) clr_pend_d = 1'b1;

    pending_d = (|dirty_d) | clr_pend_d |
                (state_d == ST_CLR_ISSUE) |
                (state_d == ST_CLR_WAIT_HI) |
                (state_d == ST_CLR_WAIT_LO);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_INIT_WAIT;
      for (int i = 0; i < 32; i++) fb_q[i] <= BLANK;
      dirty_q        <= '0;
      ptr_q          <= 5'd0;
      clr_pend_q     <= 1'b0;
      clr_req_prev_q <= 1'b0;
      gap_q          <= '0;
      to_q           <= '0;
      char_q         <= BLANK;
      addr_q         <= 8'h80;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      fb_q           <= fb_d;
      dirty_q        <= dirty_d;
      ptr_q          <= ptr_d;
      clr_pend_q     <= clr_pend_d;
      clr_req_prev_q <= clr_req_prev_d;
      gap_q          <= gap_d;
      to_q           <= to_d;
      char_q         <= char_d;
      addr_q         <= addr_d;
      pending_q      <= pending_d;
    end
  end

  // Pulses decode straight from the state register so reset removes them
  // without waiting for a clock edge.
  assign o_lcd_start = (state_q == ST_ISSUE);
  assign o_lcd_clear = (state_q == ST_CLR_ISSUE);
  assign o_lcd_char  = char_q;
  assign o_lcd_addr  = addr_q;
  assign o_pending   = pending_q;

endmodule
